// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: drives the PC register, fetches from imem over req/ack
// and hands instructions to decode over valid/ready. FETCH_TIMEOUT_EN adds an ack timeout.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC       = 32'h0000_0000,
   parameter int          TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] current_pc,
   output logic [31:0] next_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   output logic        fetch_fault
);

   typedef enum logic [1:0] {S_REQ, S_HOLD, S_DRAIN, S_HALT} state_e;

   state_e      state_q, state_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] instr_pc_q, instr_pc_d;
   logic        instr_valid_q, instr_valid_d;
   logic [31:0] drain_addr_q, drain_addr_d;
   logic        fault_q, fault_d;
   logic [31:0] pc_nxt;
   logic [31:0] redir_pc;
   logic        req;
   logic        timeout;

   assign redir_pc = redirect_target & 32'hFFFF_FFFC;

`ifdef FETCH_TIMEOUT_EN
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
   logic [7:0] wait_q, wait_d;
`endif

   always_comb begin
      state_d       = state_q;
      instr_d       = instr_q;
      instr_pc_d    = instr_pc_q;
      instr_valid_d = instr_valid_q;
      drain_addr_d  = drain_addr_q;
      fault_d       = fault_q;
      pc_nxt        = current_pc;
      req           = 1'b0;
      imem_addr     = current_pc;
      timeout       = 1'b0;
`ifdef FETCH_TIMEOUT_EN
      timeout = (state_q == S_REQ || state_q == S_DRAIN) && !imem_ack && (wait_q == TO_LAST);
`endif
      case (state_q)
         S_REQ: begin
            req = 1'b1;
            if (timeout) begin
               state_d = S_HALT;
               fault_d = 1'b1;
            end else if (redirect_valid) begin
               pc_nxt        = redir_pc;
               instr_valid_d = 1'b0;
               if (imem_ack) begin
                  state_d = S_REQ;
               end else begin
                  // the outstanding request must still complete; remember its address
                  state_d      = S_DRAIN;
                  drain_addr_d = current_pc;
               end
            end else if (imem_ack) begin
               instr_d       = imem_rdata;
               instr_pc_d    = current_pc;
               instr_valid_d = 1'b1;
               state_d       = S_HOLD;
            end
         end
         S_HOLD: begin
            if (redirect_valid) begin
               pc_nxt        = redir_pc;
               instr_valid_d = 1'b0;
               state_d       = S_REQ;
            end else if (instr_ready) begin
               pc_nxt        = current_pc + 32'd4;
               instr_valid_d = 1'b0;
               state_d       = S_REQ;
            end
         end
         S_DRAIN: begin
            req       = 1'b1;
            imem_addr = drain_addr_q;
            if (timeout) begin
               state_d = S_HALT;
               fault_d = 1'b1;
            end else begin
               if (redirect_valid) pc_nxt = redir_pc;
               if (imem_ack) state_d = S_REQ;
            end
         end
         default: begin
            instr_valid_d = 1'b0;
         end
      endcase
      // reset gates the combinational outputs immediately, not at the next edge
      if (!reset) begin
         req    = 1'b0;
         pc_nxt = RESET_PC;
      end
   end

   assign next_pc     = pc_nxt & 32'hFFFF_FFFC;
   assign imem_req    = req;
   assign instr       = instr_q;
   assign instr_pc    = instr_pc_q;
   assign instr_valid = instr_valid_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= S_REQ;
         instr_q       <= '0;
         instr_pc_q    <= '0;
         instr_valid_q <= 1'b0;
         drain_addr_q  <= '0;
      end else begin
         state_q       <= state_d;
         instr_q       <= instr_d;
         instr_pc_q    <= instr_pc_d;
         instr_valid_q <= instr_valid_d;
         drain_addr_q  <= drain_addr_d;
      end
   end

`ifdef FETCH_TIMEOUT_EN
   // counter restarts on every entry to a requesting state and on each ack
   always_comb begin
      wait_d = wait_q;
      if (state_d != state_q || imem_ack) wait_d = 8'd0;
      else if (req)                       wait_d = wait_q + 8'd1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wait_q  <= 8'd0;
         fault_q <= 1'b0;
      end else begin
         wait_q  <= wait_d;
         fault_q <= fault_d;
      end
   end
   assign fetch_fault = fault_q;
`else
   assign fault_q     = 1'b0;
   assign fetch_fault = 1'b0;
`endif

endmodule
